cook_timer: RTL and testbench

Countdown timer that feeds the microwave controller's `finish` input. The operator loads a cook time in BCD minutes:seconds. The timer counts down one second per prescaler period, but only while the controller drives `heat`, so a door-open pause freezes the count. On reaching 00:00 it holds `finish` high until the door opens or the operator clears it.

---
 rtl/cook_timer_pkg.sv | 21 ++
 rtl/cook_timer_bcd_mmss_step.sv | 48 ++++
 rtl/cook_timer.sv | 124 ++++++++++++
 tb/tb_cook_timer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cook_timer_pkg.sv
// Shared types and constants for the cook_timer block and its BCD step unit.
// The add-30 feature is controlled by COOK_TIMER_ADD30_EN.
package cook_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ct_state_t;

    localparam logic [15:0] BCD_MAX   = 16'h9959;
    localparam logic [15:0] BCD_ADD30 = 16'h0030;

    // mm:ss is valid when every digit is decimal and seconds-tens stays below 6
    function automatic logic bcd_valid(input logic [15:0] v);
        return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
               (v[7:4]   <= 4'd5) && (v[3:0]  <= 4'd9);
    endfunction

endpackage

// File: rtl/cook_timer_bcd_mmss_step.sv
// Combinational BCD mm:ss step: decrement by one second, or saturating +30 s
// when COOK_TIMER_ADD30_EN is defined.
module bcd_mmss_step
    import cook_timer_pkg::*;
(
    input  logic        op_add30,
    input  logic [15:0] time_i,
    output logic [15:0] result_o,
    output logic        zero_o
);

    logic [3:0]  m1, m0, s1, s0;
    logic [15:0] dec_val;

    assign {m1, m0, s1, s0} = time_i;

    always_comb begin
        dec_val = time_i;
        if (time_i != 16'h0000) begin
            if (s0 != 4'd0)      dec_val = {m1, m0, s1, s0 - 4'd1};
            else if (s1 != 4'd0) dec_val = {m1, m0, s1 - 4'd1, 4'd9};
            else if (m0 != 4'd0) dec_val = {m1, m0 - 4'd1, 4'd5, 4'd9};
            else                 dec_val = {m1 - 4'd1, 4'd9, 4'd5, 4'd9};
        end
    end

`ifdef COOK_TIMER_ADD30_EN
    logic [3:0]  s1_sum;
    logic [15:0] add_val;

    always_comb begin
        s1_sum = s1 + 4'd3;
        if (s1_sum < 4'd6)      add_val = {m1, m0, s1_sum, s0};
        else if (m0 != 4'd9)    add_val = {m1, m0 + 4'd1, s1_sum - 4'd6, s0};
        else if (m1 != 4'd9)    add_val = {m1 + 4'd1, 4'd0, s1_sum - 4'd6, s0};
        else                    add_val = BCD_MAX;
    end

    assign result_o = op_add30 ? add_val : dec_val;
`else
    logic unused_op_add30;
    assign unused_op_add30 = op_add30;
    assign result_o        = dec_val;
`endif

    assign zero_o = (result_o == 16'h0000);

endmodule

// File: rtl/cook_timer.sv
// Microwave cook countdown timer: BCD mm:ss load, prescaled 1 s ticks while heat is high.
// Optional +30 s quick-add is built only when COOK_TIMER_ADD30_EN is defined.
//
//   state | meaning
//   IDLE  | time is 00:00
//   ARMED | time nonzero, waiting for heat
//   RUN   | counting down
//   DONE  | reached 00:00 or stopped, finish held
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        heat,
    input  logic        door,
    input  logic        load,
    input  logic [15:0] time_in,
    input  logic        clear,
    input  logic        add30,
    output logic        finish,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        load_err
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    ct_state_t     state_q, state_d;
    logic [15:0]   time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          load_err_q, load_err_d;

    logic          presc_run, tick, do_add30;
    logic [15:0]   step_res;
    logic          step_zero;

`ifdef COOK_TIMER_ADD30_EN
    assign do_add30 = add30;
`else
    logic unused_add30;
    assign unused_add30 = add30;
    assign do_add30     = 1'b0;
`endif

    bcd_mmss_step u_step (
        .op_add30 (do_add30),
        .time_i   (time_q),
        .result_o (step_res),
        .zero_o   (step_zero)
    );

    assign presc_run = (state_q == RUN) && heat;
    assign tick      = presc_run && (presc_q == PRESC_LAST);

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        presc_d    = presc_q;
        load_err_d = 1'b0;

        if (presc_run) presc_d = tick ? '0 : presc_q + PW'(1);

        if (clear) begin
            state_d = (state_q == RUN) ? DONE : IDLE;
            time_d  = 16'h0000;
            presc_d = '0;
        end else if (load && (state_q == IDLE || state_q == ARMED)) begin
            if (!bcd_valid(time_in)) begin
                load_err_d = 1'b1;
            end else begin
                state_d = (time_in == 16'h0000) ? IDLE : ARMED;
                time_d  = time_in;
                presc_d = '0;
            end
        end else if (do_add30) begin
            // a tick colliding with add30 is dropped; the prescaler keeps running
            case (state_q)
                RUN:  time_d = step_res;
                DONE: begin
                    state_d = ARMED;
                    time_d  = BCD_ADD30;
                    presc_d = '0;
                end
                default: begin
                    state_d = ARMED;
                    time_d  = step_res;
                end
            endcase
        end else if (tick) begin
            time_d = step_res;
            if (step_zero) state_d = DONE;
        end else begin
            case (state_q)
                ARMED:   if (heat)  state_d = RUN;
                RUN:     if (!heat) state_d = ARMED;
                DONE:    if (door)  state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            time_q     <= 16'h0000;
            presc_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            load_err_q <= load_err_d;
        end
    end

    assign finish   = (state_q == DONE);
    assign running  = (state_q == RUN);
    assign time_bcd = time_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_cook_timer.sv
// Directed self-checking bench for cook_timer with TICK_DIV=4.
module tb_cook_timer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        heat, door, load, clear, add30;
    logic [15:0] time_in;
    logic        finish, running, load_err;
    logic [15:0] time_bcd;

    int pass_cnt = 0;
    int total_cnt = 0;

    cook_timer #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .heat     (heat),
        .door     (door),
        .load     (load),
        .time_in  (time_in),
        .clear    (clear),
        .add30    (add30),
        .finish   (finish),
        .time_bcd (time_bcd),
        .running  (running),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic [15:0] t, input logic f,
                              input logic r, input logic e);
        check({tag, ".time"}, time_bcd, t);
        check({tag, ".finish"}, {15'd0, finish}, {15'd0, f});
        check({tag, ".running"}, {15'd0, running}, {15'd0, r});
        check({tag, ".load_err"}, {15'd0, load_err}, {15'd0, e});
    endtask

    initial begin
        nrst = 1'b0; heat = 1'b0; door = 1'b0; load = 1'b0;
        clear = 1'b0; add30 = 1'b0; time_in = 16'h0000;
        step(2);
        check_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        nrst = 1'b1;
        step();

        // 01:02 full countdown: ticks every 4 cycles, finish 248 cycles after RUN entry
        time_in = 16'h0102; load = 1'b1;
        step();
        load = 1'b0; heat = 1'b1;
        check_outs("load0102", 16'h0102, 1'b0, 1'b0, 1'b0);
        step();
        check("run_entry.running", {15'd0, running}, 16'd1);
        step(3);
        check("pre_tick", time_bcd, 16'h0102);
        step();
        check("tick1", time_bcd, 16'h0101);
        step(4);
        check("tick2", time_bcd, 16'h0100);
        step(4);
        check("borrow_min", time_bcd, 16'h0059);
        step(235);
        check_outs("cyc247", 16'h0001, 1'b0, 1'b1, 1'b0);
        step();
        check_outs("cyc248_done", 16'h0000, 1'b1, 1'b0, 1'b0);
        door = 1'b1;
        step();
        door = 1'b0; heat = 1'b0;
        check_outs("door_release", 16'h0000, 1'b0, 1'b0, 1'b0);

        // pause with prescaler at 2, resume ticks after 2 cycles
        time_in = 16'h0003; load = 1'b1;
        step();
        load = 1'b0; heat = 1'b1;
        step(7);
        check("pause_pre", time_bcd, 16'h0002);
        heat = 1'b0;
        step();
        check_outs("paused", 16'h0002, 1'b0, 1'b0, 1'b0);
        step(9);
        check_outs("paused_end", 16'h0002, 1'b0, 1'b0, 1'b0);
        heat = 1'b1;
        step();
        check_outs("resume", 16'h0002, 1'b0, 1'b1, 1'b0);
        step();
        check("resume_plus1", time_bcd, 16'h0002);
        step();
        check("resume_plus2", time_bcd, 16'h0001);
        clear = 1'b1;
        step();
        check_outs("clear_run", 16'h0000, 1'b1, 1'b0, 1'b0);
        step();
        clear = 1'b0; heat = 1'b0;
        check_outs("clear_done", 16'h0000, 1'b0, 1'b0, 1'b0);

        // invalid loads from ARMED
        time_in = 16'h0200; load = 1'b1;
        step();
        time_in = 16'h0070;
        step();
        load = 1'b0;
        check_outs("err_0070", 16'h0200, 1'b0, 1'b0, 1'b1);
        step();
        check("err_0070_drop", {15'd0, load_err}, 16'd0);
        time_in = 16'h00A0; load = 1'b1;
        step();
        load = 1'b0;
        check_outs("err_00A0", 16'h0200, 1'b0, 1'b0, 1'b1);
        step();
        check("err_00A0_drop", {15'd0, load_err}, 16'd0);

        // valid zero load from ARMED returns to IDLE; heat then has no effect
        time_in = 16'h0000; load = 1'b1;
        step();
        load = 1'b0; heat = 1'b1;
        check("load_zero", time_bcd, 16'h0000);
        step();
        check("idle_ignores_heat", {15'd0, running}, 16'd0);
        heat = 1'b0;

        // clear during RUN at 00:45
        time_in = 16'h0045; load = 1'b1;
        step();
        load = 1'b0; heat = 1'b1;
        step();
        check("run_0045", {15'd0, running}, 16'd1);
        clear = 1'b1;
        step();
        clear = 1'b0; heat = 1'b0;
        check_outs("stop_0045", 16'h0000, 1'b1, 1'b0, 1'b0);
        door = 1'b1;
        step();
        door = 1'b0;
        check("door_idle", {15'd0, finish}, 16'd0);

        // load+clear together from ARMED, then load ignored in RUN
        time_in = 16'h0300; load = 1'b1;
        step();
        time_in = 16'h0500; clear = 1'b1;
        step();
        load = 1'b0; clear = 1'b0;
        check_outs("load_clear", 16'h0000, 1'b0, 1'b0, 1'b0);
        time_in = 16'h0300; load = 1'b1;
        step();
        load = 1'b0; heat = 1'b1;
        step();
        time_in = 16'h0100; load = 1'b1;
        step();
        check_outs("load_in_run", 16'h0300, 1'b0, 1'b1, 1'b0);
        time_in = 16'h00A0;
        step();
        load = 1'b0;
        check_outs("badload_in_run", 16'h0300, 1'b0, 1'b1, 1'b0);
        clear = 1'b1;
        step(2);
        clear = 1'b0; heat = 1'b0;
        check("back_idle", time_bcd, 16'h0000);

`ifdef COOK_TIMER_ADD30_EN
        time_in = 16'h9945; load = 1'b1;
        step();
        load = 1'b0; add30 = 1'b1;
        step();
        add30 = 1'b0;
        check_outs("add30_sat", 16'h9959, 1'b0, 1'b0, 1'b0);
        time_in = 16'h0100; load = 1'b1;
        step();
        load = 1'b0; heat = 1'b1;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0; heat = 1'b0;
        check("pre_add30_done", {15'd0, finish}, 16'd1);
        add30 = 1'b1;
        step();
        add30 = 1'b0;
        check_outs("add30_done", 16'h0030, 1'b0, 1'b0, 1'b0);
        time_in = 16'h0045; load = 1'b1;
        step();
        load = 1'b0; add30 = 1'b1;
        step();
        add30 = 1'b0;
        check_outs("add30_carry", 16'h0115, 1'b0, 1'b0, 1'b0);
`else
        time_in = 16'h0045; load = 1'b1;
        step();
        load = 1'b0; add30 = 1'b1;
        step();
        add30 = 1'b0;
        check_outs("add30_ignored", 16'h0045, 1'b0, 1'b0, 1'b0);
        heat = 1'b1;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0; heat = 1'b0; add30 = 1'b1;
        step();
        add30 = 1'b0;
        check_outs("add30_ignored_done", 16'h0000, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
`endif

        // asynchronous reset from RUN
        time_in = 16'h0100; load = 1'b1;
        step();
        load = 1'b0; heat = 1'b1;
        step();
        check("pre_async", {15'd0, running}, 16'd1);
        #2;
        nrst = 1'b0;
        #1;
        check_outs("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        heat = 1'b0;
        nrst = 1'b1;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
